// File: rtl/mem_access_sequencer.sv
// Memory port sequencer: arbitrates instruction fetch against data load/store
// and drives the registered control inputs of memory_datapath.
module mem_access_sequencer #(
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       fetch_req,
  output logic       fetch_ack,
  input  logic       data_req,
  input  logic       data_we,
  input  logic       data_addr_sel,
  input  logic [2:0] data_dst,
  output logic       data_ack,
  output logic [1:0] MemSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [2:0] MemDst,
  output logic       MaryWrite,
  output logic       ShelleyWrite,
  output logic       CompWrite,
  output logic       RAWrite,
  output logic       busy
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [1:0]    LAT_LAST   = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DREAD,
    S_DWRITE,
    S_WB,
    S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_lat_cnt, w_lat_nxt;
  logic [SW-1:0] r_starve_cnt, w_starve_nxt;
  logic          r_sel, w_sel_nxt;
  logic [2:0]    r_dst, w_dst_nxt;
  logic          r_is_fetch, w_is_fetch_nxt;

  logic          r_fetch_ack, w_fetch_ack;
  logic          r_data_ack, w_data_ack;
  logic [1:0]    r_mem_src, w_mem_src;
  logic          r_mem_read, w_mem_read;
  logic          r_mem_write, w_mem_write;
  logic [2:0]    r_mem_dst, w_mem_dst;
  logic [3:0]    r_strobe, w_strobe;     // {Mary, Shelley, Comp, RA}
  logic          r_busy, w_busy;

  // Outputs are decoded from the *next* state so that they are registered
  // together with the state and are valid for the whole cycle of that state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned, which would otherwise infer a latch.
    w_state_nxt    = r_state;
    w_lat_nxt      = r_lat_cnt;
    w_starve_nxt   = r_starve_cnt;
    w_sel_nxt      = r_sel;
    w_dst_nxt      = r_dst;
    w_is_fetch_nxt = r_is_fetch;
    w_fetch_ack    = 1'b0;
    w_data_ack     = 1'b0;
    w_mem_src      = 2'b00;
    w_mem_read     = 1'b0;
    w_mem_write    = 1'b0;
    w_mem_dst      = 3'b000;
    w_strobe       = 4'b0000;

    case (r_state)
      S_IDLE: begin
        if (fetch_req || data_req) begin
          w_sel_nxt = data_addr_sel;
          w_dst_nxt = data_dst;
          if (fetch_req && (!data_req || r_starve_cnt == STARVE_MAX)) begin
            w_is_fetch_nxt = 1'b1;
            w_state_nxt    = S_FETCH;
            w_starve_nxt   = '0;
          end else begin
            w_is_fetch_nxt = 1'b0;
            w_state_nxt    = data_we ? S_DWRITE : S_DREAD;
            if (!fetch_req)
              w_starve_nxt = '0;
            else if (r_starve_cnt != STARVE_MAX)
              w_starve_nxt = r_starve_cnt + 1'b1;
          end
        end
      end
      S_FETCH, S_DREAD: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_lat_nxt   = 2'd0;
          w_state_nxt = (r_state == S_FETCH) ? S_DONE : S_WB;
        end else begin
          w_lat_nxt = r_lat_cnt + 2'd1;
        end
      end
      S_DWRITE: w_state_nxt = S_DONE;
      S_WB:     w_state_nxt = S_IDLE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_FETCH: w_mem_read = 1'b1;
      S_DREAD: begin
        w_mem_src  = w_sel_nxt ? 2'b10 : 2'b01;
        w_mem_read = 1'b1;
        w_mem_dst  = w_dst_nxt;
      end
      S_WB: begin
        w_mem_src  = w_sel_nxt ? 2'b10 : 2'b01;
        w_mem_read = 1'b1;
        w_mem_dst  = w_dst_nxt;
        w_data_ack = 1'b1;
        case (w_dst_nxt)
          3'b001:  w_strobe = 4'b1000;
          3'b010:  w_strobe = 4'b0100;
          3'b011:  w_strobe = 4'b0010;
          3'b100:  w_strobe = 4'b0001;
          default: w_strobe = 4'b0000;
        endcase
      end
      S_DWRITE: begin
        w_mem_src   = w_sel_nxt ? 2'b10 : 2'b01;
        w_mem_write = 1'b1;
      end
      S_DONE: begin
        if (w_is_fetch_nxt) begin
          w_mem_read  = 1'b1;  // keeps mem_out stable for the instruction
          w_fetch_ack = 1'b1;
        end else begin
          w_mem_src  = w_sel_nxt ? 2'b10 : 2'b01;
          w_data_ack = 1'b1;
        end
      end
      default: ;
    endcase

    w_busy = (w_state_nxt != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= 2'd0;
      r_starve_cnt <= '0;
      r_sel        <= 1'b0;
      r_dst        <= 3'b000;
      r_is_fetch   <= 1'b0;
      r_fetch_ack  <= 1'b0;
      r_data_ack   <= 1'b0;
      r_mem_src    <= 2'b00;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_dst    <= 3'b000;
      r_strobe     <= 4'b0000;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lat_cnt    <= w_lat_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_sel        <= w_sel_nxt;
      r_dst        <= w_dst_nxt;
      r_is_fetch   <= w_is_fetch_nxt;
      r_fetch_ack  <= w_fetch_ack;
      r_data_ack   <= w_data_ack;
      r_mem_src    <= w_mem_src;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_mem_dst    <= w_mem_dst;
      r_strobe     <= w_strobe;
      r_busy       <= w_busy;
    end
  end

  assign fetch_ack    = r_fetch_ack;
  assign data_ack     = r_data_ack;
  assign MemSrc       = r_mem_src;
  assign MemRead      = r_mem_read;
  assign MemWrite     = r_mem_write;
  assign MemDst       = r_mem_dst;
  assign MaryWrite    = r_strobe[3];
  assign ShelleyWrite = r_strobe[2];
  assign CompWrite    = r_strobe[1];
  assign RAWrite      = r_strobe[0];
  assign busy         = r_busy;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: scoreboard of expected acks
// against a small memory model, plus a READ_LATENCY=3 instance.
module tb_mem_access_sequencer;

  localparam int RL = 1;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // Main instance (READ_LATENCY = 1)
  logic       fetch_req, data_req, data_we, data_addr_sel;
  logic [2:0] data_dst;
  logic       fetch_ack, data_ack, MemRead, MemWrite, busy;
  logic       MaryWrite, ShelleyWrite, CompWrite, RAWrite;
  logic [1:0] MemSrc;
  logic [2:0] MemDst;
  logic [3:0] strobes;
  logic [13:0] outs;
  assign strobes = {MaryWrite, ShelleyWrite, CompWrite, RAWrite};
  assign outs = {fetch_ack, data_ack, MemSrc, MemRead, MemWrite, MemDst, strobes, busy};

  // Long-latency instance (READ_LATENCY = 3)
  logic       fetch_req3, data_req3, data_we3, data_addr_sel3;
  logic [2:0] data_dst3;
  logic       fetch_ack3, data_ack3, MemRead3, MemWrite3, busy3;
  logic       MaryWrite3, ShelleyWrite3, CompWrite3, RAWrite3;
  logic [1:0] MemSrc3;
  logic [2:0] MemDst3;
  logic [3:0] strobes3;
  logic [13:0] outs3;
  assign strobes3 = {MaryWrite3, ShelleyWrite3, CompWrite3, RAWrite3};
  assign outs3 = {fetch_ack3, data_ack3, MemSrc3, MemRead3, MemWrite3, MemDst3, strobes3, busy3};

  mem_access_sequencer #(.READ_LATENCY(RL), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_ack(fetch_ack),
    .data_req(data_req), .data_we(data_we), .data_addr_sel(data_addr_sel),
    .data_dst(data_dst), .data_ack(data_ack),
    .MemSrc(MemSrc), .MemRead(MemRead), .MemWrite(MemWrite), .MemDst(MemDst),
    .MaryWrite(MaryWrite), .ShelleyWrite(ShelleyWrite), .CompWrite(CompWrite),
    .RAWrite(RAWrite), .busy(busy)
  );

  mem_access_sequencer #(.READ_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clock(clock), .reset_n(reset_n),
    .fetch_req(fetch_req3), .fetch_ack(fetch_ack3),
    .data_req(data_req3), .data_we(data_we3), .data_addr_sel(data_addr_sel3),
    .data_dst(data_dst3), .data_ack(data_ack3),
    .MemSrc(MemSrc3), .MemRead(MemRead3), .MemWrite(MemWrite3), .MemDst(MemDst3),
    .MaryWrite(MaryWrite3), .ShelleyWrite(ShelleyWrite3), .CompWrite(CompWrite3),
    .RAWrite(RAWrite3), .busy(busy3)
  );

  // Minimal memory_datapath stand-in: address mux, memory, write port.
  logic [15:0] pc, reg_in, sp_in, mary_data, addr, mem_out;
  logic [15:0] mem [256];
  assign addr    = (MemSrc == 2'b01) ? reg_in : (MemSrc == 2'b10) ? sp_in : pc;
  assign mem_out = mem[addr[7:0]];
  always @(posedge clock) if (MemWrite) mem[addr[7:0]] <= mary_data;

  // Scoreboard
  typedef struct {
    bit          is_fetch;
    bit          is_load;
    int          lat;
    int          rd;
    int          wr;
    logic [1:0]  src;
    logic [2:0]  dst;
    logic [3:0]  strobes;
    bit          chk_data;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_acks  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] dst_strobe(input logic [2:0] dst);
    case (dst)
      3'b001:  return 4'b1000;
      3'b010:  return 4'b0100;
      3'b011:  return 4'b0010;
      3'b100:  return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic exp_t mk_exp(input bit is_fetch, input bit we, input bit sel,
                                  input logic [2:0] dst, input bit chk, input logic [15:0] data);
    exp_t e;
    e.is_fetch = is_fetch;
    e.is_load  = !is_fetch && !we;
    e.chk_data = chk;
    e.data     = data;
    e.src      = is_fetch ? 2'b00 : (sel ? 2'b10 : 2'b01);
    e.dst      = e.is_load ? dst : 3'b000;
    e.strobes  = e.is_load ? dst_strobe(dst) : 4'b0000;
    e.lat      = (is_fetch || !we) ? RL : 1;
    e.rd       = (is_fetch || !we) ? RL + 1 : 0;
    e.wr       = (!is_fetch && we) ? 1 : 0;
    return e;
  endfunction

  // Monitor on the main instance, sampled on the falling edge.
  int   ncyc = 0, start_cyc = 0, rd_run = 0, wr_run = 0;
  bit   busy_q = 0, ack_q = 0;
  exp_t e_mon;

  always @(negedge clock) begin
    ncyc++;
    if (ack_q) check("idle_after_ack", 32'(busy), 32'd0);
    if (busy && !busy_q) begin
      start_cyc = ncyc;
      rd_run    = 0;
      wr_run    = 0;
    end
    if (MemRead)  rd_run++;
    if (MemWrite) wr_run++;
    if (MemWrite) check("rw_exclusive", 32'(MemRead), 32'd0);
    if (busy && sb.size() > 0) begin
      check("memdst", 32'(MemDst), 32'(sb[0].dst));
      if (MemRead || MemWrite) check("memsrc", 32'(MemSrc), 32'(sb[0].src));
      if (!(fetch_ack || data_ack)) check("strobe_early", 32'(strobes), 32'd0);
    end
    if (fetch_ack || data_ack) begin
      n_acks++;
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'({fetch_ack, data_ack}), 32'd0);
      end else begin
        e_mon = sb.pop_front();
        check("ack_kind", 32'({fetch_ack, data_ack}), e_mon.is_fetch ? 32'd2 : 32'd1);
        check("ack_latency", 32'(ncyc - start_cyc), 32'(e_mon.lat));
        check("read_cycles", 32'(rd_run), 32'(e_mon.rd));
        check("write_cycles", 32'(wr_run), 32'(e_mon.wr));
        check("strobes", 32'(strobes), 32'(e_mon.strobes));
        if (e_mon.chk_data) check("mem_out", 32'(mem_out), 32'(e_mon.data));
      end
    end
    ack_q  = fetch_ack || data_ack;
    busy_q = busy;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_acks(input int n, input int budget);
    int target = n_acks + n;
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      #1;
      if (n_acks >= target) begin
        got = 1'b1;
        break;
      end
    end
    check("ack_timeout", 32'(got), 32'd1);
  endtask

  // One request through the handshake; inputs are scrambled after the grant
  // to prove they were captured. hold=0 drops req right after the grant.
  task automatic do_op(input bit is_fetch, input bit we, input bit sel, input logic [2:0] dst,
                       input bit hold, input bit chk, input logic [15:0] data);
    sb.push_back(mk_exp(is_fetch, we, sel, dst, chk, data));
    data_we = we;
    data_addr_sel = sel;
    data_dst = dst;
    if (is_fetch) fetch_req = 1'b1;
    else          data_req  = 1'b1;
    step();
    data_we = ~we;
    data_addr_sel = ~sel;
    data_dst = ~dst;
    if (!hold) begin
      fetch_req = 1'b0;
      data_req  = 1'b0;
    end
    wait_acks(1, 20);
    step();
    fetch_req = 1'b0;
    data_req  = 1'b0;
  endtask

  logic [2:0] dst_tab [7] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000, 3'b111, 3'b101};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    {fetch_req, data_req, data_we, data_addr_sel, data_dst} = '0;
    {fetch_req3, data_req3, data_we3, data_addr_sel3, data_dst3} = '0;
    pc = 16'h0010;
    reg_in = 16'h0001;
    sp_in = 16'h00FF;
    mary_data = 16'd127;
    for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    mem[8'h10] <= 16'hBEEF;
    mem[8'hFF] <= 16'h1234;

    #12;
    check("reset_outs", 32'(outs), 32'd0);
    check("reset_outs3", 32'(outs3), 32'd0);
    #10 reset_n = 1'b1;
    step();

    // Fetch from pc
    do_op(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 16'hBEEF);

    // Store 127 to reg_in address, then load it back into Shelley
    do_op(1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 16'h0000);
    do_op(1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 16'd127);

    // Destination decode through sp_in, including null codes
    for (int i = 0; i < 7; i++)
      do_op(1'b0, 1'b0, 1'b1, dst_tab[i], 1'b1, 1'b1, 16'h1234);

    // Requests dropped right after the grant still complete
    do_op(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 16'hBEEF);
    do_op(1'b0, 1'b0, 1'b0, 3'b011, 1'b0, 1'b1, 16'd127);

    // Arbitration: both requests held -> D,D,D,D,F,D,D,D,D,F
    for (int i = 0; i < 10; i++)
      sb.push_back(mk_exp((i == 4) || (i == 9), 1'b1, 1'b0, 3'b000, 1'b0, 16'h0000));
    data_we = 1'b1;
    data_addr_sel = 1'b0;
    data_dst = 3'b000;
    fetch_req = 1'b1;
    data_req = 1'b1;
    wait_acks(10, 200);
    step();
    fetch_req = 1'b0;
    data_req = 1'b0;
    check("arb_sb_drained", 32'(sb.size()), 32'd0);
    step();

    // Reset in the middle of a store
    sb.push_back(mk_exp(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 16'h0000));
    data_we = 1'b1;
    data_addr_sel = 1'b0;
    data_req = 1'b1;
    step();
    check("rst_pre_memwrite", 32'(MemWrite), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_outs", 32'(outs), 32'd0);
    sb.delete();
    data_req = 1'b0;
    step();
    step();
    #2 reset_n = 1'b1;
    step();
    check("rst_release_idle", 32'(outs), 32'd0);
    do_op(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 16'hBEEF);

    // READ_LATENCY = 3 load from sp_in into RA: 3 read cycles, then WB
    data_we3 = 1'b0;
    data_addr_sel3 = 1'b1;
    data_dst3 = 3'b100;
    data_req3 = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rl3_dread", 32'({MemRead3, MemSrc3, MemDst3, strobes3, data_ack3, busy3}),
            32'({1'b1, 2'b10, 3'b100, 4'b0000, 1'b0, 1'b1}));
    end
    @(negedge clock);
    check("rl3_wb", 32'({MemRead3, MemSrc3, MemDst3, strobes3, data_ack3, busy3}),
          32'({1'b1, 2'b10, 3'b100, 4'b0001, 1'b1, 1'b1}));
    step();
    data_req3 = 1'b0;
    @(negedge clock);
    check("rl3_idle", 32'(outs3), 32'd0);
    step();
    step();

    check("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
